jtag_scan_master: RTL

- JTAG initiator: drives tck/tms/tdi into a TAP target and samples its tdo.
- Converts single-beat scan commands (TAP reset, IR scan, DR scan, idle clocks) into TMS/TDI bit sequences and returns the captured TDO bits.
- Sits between a host-side command source and the JTAG pins of a TAP slave, e.g. the ahbjtag TAP in our OOC designs.
- Used as the stimulus/driver end of JTAG links in board-level and OOC test tops.

---
 rtl/jtag_scan_master.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/jtag_scan_master.sv
// rtl/jtag_scan_master.sv - JTAG initiator turning scan commands into TCK/TMS/TDI sequences
// Optional trst_n output is enabled by defining JTAG_SCAN_MASTER_TRST_EN.
module jtag_scan_master #(
    parameter int MAX_LEN = 64,
    parameter int CLK_DIV = 2,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               busy,
    output logic               tck,
    output logic               tms,
    output logic               tdi,
`ifdef JTAG_SCAN_MASTER_TRST_EN
    output logic               trst_n,
`endif
    input  logic               tdo
);
    localparam int DIV_W = $clog2(2 * CLK_DIV);
    localparam logic [1:0] OP_RESET = 2'd0;
    localparam logic [1:0] OP_IR    = 2'd1;
    localparam logic [1:0] OP_DR    = 2'd2;
    localparam logic [1:0] OP_RUN   = 2'd3;

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_PRE, S_SHIFT, S_POST, S_WAIT, S_RESP} state_t;

    state_t             state;
    logic [1:0]         op_q;
    logic [LEN_W-1:0]   len_q;
    logic [MAX_LEN-1:0] data_q;
    logic [LEN_W-1:0]   bit_idx;
    logic [DIV_W-1:0]   div_cnt;
    logic [LEN_W-1:0]   len_c;

    logic [LEN_W-1:0]   seq_len;
    logic [LEN_W-1:0]   nxt_idx;
    state_t             follow;
    state_t             nxt_st;
    logic               nxt_tms;
    logic               nxt_tdi;

    assign len_c = (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;

    // Where the bit engine goes at the next TCK fall: next bit of this phase or first bit of the next
    always_comb begin
        seq_len = LEN_W'(1);
        follow  = S_IDLE;
        case (state)
            S_INIT:  begin seq_len = LEN_W'(6); follow = S_IDLE; end
            S_PRE: begin
                seq_len = (op_q == OP_IR) ? LEN_W'(4) : (op_q == OP_DR) ? LEN_W'(3) : LEN_W'(5);
                follow  = (op_q == OP_RESET) ? S_POST : S_SHIFT;
            end
            S_SHIFT: begin seq_len = len_q; follow = S_POST; end
            S_POST:  begin seq_len = (op_q == OP_RESET) ? LEN_W'(1) : LEN_W'(2); follow = S_RESP; end
            S_WAIT:  begin seq_len = len_q; follow = S_RESP; end
            default: ;
        endcase
        nxt_st  = (bit_idx == seq_len - LEN_W'(1)) ? follow : state;
        nxt_idx = (nxt_st != state) ? '0 : bit_idx + LEN_W'(1);
        nxt_tms = 1'b0;
        nxt_tdi = 1'b0;
        case (nxt_st)
            S_INIT:  nxt_tms = (nxt_idx < LEN_W'(5));
            S_PRE:   nxt_tms = (op_q == OP_IR) ? (nxt_idx < LEN_W'(2)) :
                               (op_q == OP_DR) ? (nxt_idx == '0) : 1'b1;
            S_SHIFT: begin
                nxt_tms = (nxt_idx == len_q - LEN_W'(1));
                nxt_tdi = |(data_q & ({{(MAX_LEN-1){1'b0}}, 1'b1} << nxt_idx));
            end
            S_POST:  nxt_tms = (op_q != OP_RESET) && (nxt_idx == '0);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_INIT;
            tck       <= 1'b0;
            tms       <= 1'b1;
            tdi       <= 1'b0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            busy      <= 1'b1;
            div_cnt   <= '0;
            bit_idx   <= '0;
            op_q      <= OP_RESET;
            len_q     <= '0;
            data_q    <= '0;
`ifdef JTAG_SCAN_MASTER_TRST_EN
            trst_n    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: if (cmd_valid) begin
                    op_q      <= cmd_op;
                    len_q     <= len_c;
                    data_q    <= cmd_data;
                    rsp_data  <= '0;
                    cmd_ready <= 1'b0;
                    busy      <= 1'b1;
                    bit_idx   <= '0;
                    div_cnt   <= '0;
                    if (cmd_op == OP_RESET) begin
                        state <= S_PRE;
                        tms   <= 1'b1;
`ifdef JTAG_SCAN_MASTER_TRST_EN
                        trst_n <= 1'b0;
`endif
                    end else if (len_c == '0) begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                    end else if (cmd_op == OP_RUN) begin
                        state <= S_WAIT;
                        tms   <= 1'b0;
                    end else begin
                        state <= S_PRE;
                        tms   <= 1'b1;
                    end
                end
                S_RESP: if (rsp_ready) begin
                    state     <= S_IDLE;
                    rsp_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
`ifdef JTAG_SCAN_MASTER_TRST_EN
                    // Hold the TAP in hardware reset for one TCK period before the TMS init
                    if (!trst_n && state == S_INIT) begin
                        if (div_cnt == DIV_W'(2 * CLK_DIV - 1)) begin
                            div_cnt <= '0;
                            trst_n  <= 1'b1;
                        end else begin
                            div_cnt <= div_cnt + DIV_W'(1);
                        end
                    end else
`endif
                    if (div_cnt != DIV_W'(CLK_DIV - 1)) begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end else begin
                        div_cnt <= '0;
                        if (!tck) begin
                            tck <= 1'b1;
                            if (state == S_SHIFT)
                                rsp_data <= rsp_data | ({{(MAX_LEN-1){1'b0}}, tdo} << bit_idx);
                        end else begin
                            tck       <= 1'b0;
                            state     <= nxt_st;
                            bit_idx   <= nxt_idx;
                            tms       <= nxt_tms;
                            tdi       <= nxt_tdi;
                            busy      <= (nxt_st != S_IDLE);
                            cmd_ready <= (nxt_st == S_IDLE);
                            rsp_valid <= (nxt_st == S_RESP);
`ifdef JTAG_SCAN_MASTER_TRST_EN
                            if (state == S_PRE && nxt_st != S_PRE)
                                trst_n <= 1'b1;
`endif
                        end
                    end
                end
            endcase
        end
    end
endmodule
